param_fifo: RTL
===============

# param_fifo

Parametrised synchronous FIFO: the next generation of the team's 8-bit × 16 FIFO. It adds configurable data width and depth, simultaneous read/write in one cycle, and almost-full/almost-empty thresholds. It also provides an occupancy count and sticky overflow/underflow error flags. It sits between AHB/APB bridge stages and peripheral data paths as the standard single-clock buffer, with an optional first-word-fall-through read mode.

## Interface
- `DATA_W`, 8, data word width in bits (≥1)
- `DEPTH`, 16, number of entries; power of two, ≥2
- `AFULL_THR`, DEPTH-2, `almost_full` asserts when count ≥ AFULL_THR (1..DEPTH)
- `AEMPTY_THR`, 2, `almost_empty` asserts when count ≤ AEMPTY_THR (0..DEPTH-1)

- `clk` in 1: sole clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `wr` in 1: write request
- `din` in DATA_W: write data
- `rd` in 1: read request (pop)
- `clr_err` in 1: synchronous clear of sticky error flags
- `dout` out DATA_W: read data
- `full` out 1: count == DEPTH
- `empty` out 1: count == 0
- `almost_full` out 1: count ≥ AFULL_THR
- `almost_empty` out 1: count ≤ AEMPTY_THR
- `count` out $clog2(DEPTH)+1: current occupancy
- `overflow` out 1: sticky, a write was dropped
- `underflow` out 1: sticky, a read was dropped

## Operation
- **Pointers:** `wptr` and `rptr` are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. `count` is tracked separately; flags decode from `count` combinationally.
- **Write acceptance:** `wr_ok = wr & (~full | rd)`. When the FIFO is full, a write is accepted only if a read is accepted in the same cycle.
- **Read acceptance:** `rd_ok = rd & ~empty`. When the FIFO is empty, a read is never accepted, even if a write arrives in the same cycle.
- **Write action:** on `wr_ok`, `mem[wptr] <= din` and `wptr++`.
- **Read action:** on `rd_ok`, `rptr++`.
- **Count update:**
  - +1 on `wr_ok` & ~`rd_ok`
  - −1 on `rd_ok` & ~`wr_ok`
  - unchanged when both or neither occur
- **Overflow:** `wr & ~wr_ok` sets `overflow`. State is unchanged and the data is discarded.
- **Underflow:** `rd & ~rd_ok` sets `underflow`. Pointers and `dout` are unchanged.
- **Error clear:** `clr_err` clears both sticky flags. A set event in the same cycle as `clr_err` wins, so the flag stays 1.
- **Memory reset:** memory contents are not reset.

## Timing
- **Reset (`rst_n`=0, asynchronous):**
  - pointers and `count` go to 0
  - `dout` goes to 0
  - `overflow` and `underflow` go to 0
  - resulting outputs: `empty`=1, `full`=0, `almost_empty`=1, `almost_full`=0 when AFULL_THR>0
- **Reset release:** synchronous to `clk`; the first accepted operation is at the first rising edge with `rst_n`=1.
- **Reset mid-operation:** all in-flight data is discarded; the FIFO is empty the instant `rst_n` falls.
- **Write latency:** `count`, `empty` and `full` reflect a write one cycle after the accepting edge.
- **Standard read (macro off):**
  - `dout <= mem[rptr]` on `rd_ok`; data is valid the cycle after `rd`
  - `dout` holds between reads
- **Write-to-read latency:** data written at edge N is readable by a `rd` sampled at edge N+1.
- **Full with rd & wr:** count stays DEPTH; head is popped, new word is stored at the tail.
- **Empty with rd & wr:** write is accepted, `underflow` sets, count becomes 1.

## Configuration
- **Macro:** `PARAM_FIFO_FWFT_EN`.
- **When defined (first-word-fall-through):**
  - `dout = empty ? 0 : mem[rptr]` combinationally
  - the head word is visible without a read; `rd` acts as the pop acknowledge
  - first written word appears on `dout` one cycle after its write edge
- **When undefined:** standard registered read as described under Timing.
- All other behaviour is identical in both modes.

## Test plan
All scenarios use DATA_W=8, DEPTH=16, AFULL_THR=14, AEMPTY_THR=2.

1. **Fill then drain.**
   - Stimulus: write 0x00..0x0F on 16 cycles, then 16 reads.
   - Response: `full`=1 after write 16, `almost_full` from count 14; `dout` sequence 0x00..0x0F; `empty`=1 at end; no error flags.
2. **Overflow.**
   - Stimulus: at full, `wr`=1 with `din`=0xAA and `rd`=0.
   - Response: count stays 16, `overflow`=1; 0xAA is never read; `clr_err` returns `overflow` to 0.
3. **Underflow on empty with rd & wr.**
   - Stimulus: at empty, `rd`=1 and `wr`=1 with `din`=0x55.
   - Response: `underflow`=1, count=1; the next read returns 0x55.
4. **Full with rd & wr, plus wrap-around.**
   - Stimulus: at full (head 0x00), `rd`=`wr`=1 with `din`=0x77 for 20 cycles.
   - Response: count stays 16, `full` stays 1; popped order continues with no loss; pointers wrap past 15.
5. **Asynchronous reset mid-stream.**
   - Stimulus: count=9, drop `rst_n` between clock edges.
   - Response: immediately count=0, `empty`=1, `dout`=0x00, flags 0.
6. **FWFT build.**
   - Stimulus: build with `PARAM_FIFO_FWFT_EN` defined; write 0x3C.
   - Response: `dout`=0x3C on the next cycle with no `rd`; `rd` pops it and `dout` returns to 0x00 with `empty`=1.

Source files
------------

// File: rtl/param_fifo.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty thresholds and sticky error flags.
// Define PARAM_FIFO_FWFT_EN for a first-word-fall-through read port; otherwise dout is registered on pop.
module param_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 16,
  parameter int AFULL_THR  = DEPTH - 2,
  parameter int AEMPTY_THR = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr,
  input  logic [DATA_W-1:0]       din,
  input  logic                    rd,
  input  logic                    clr_err,
  output logic [DATA_W-1:0]       dout,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_THR);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THR);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic              wr_ok;
  logic              rd_ok;

  // Flags are pure decodes of the occupancy count.
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AFULL_C);
  assign almost_empty = (count <= AEMPTY_C);

  // A full FIFO still takes a write when the head is popped in the same cycle.
  assign wr_ok = wr & (~full | rd);
  assign rd_ok = rd & ~empty;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + AW'(1);
      if (rd_ok) rptr <= rptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky errors: a new error event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr & ~wr_ok)  overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (rd & ~rd_ok)   underflow <= 1'b1;
      else if (clr_err)  underflow <= 1'b0;
    end
  end

`ifdef PARAM_FIFO_FWFT_EN
  assign dout = empty ? '0 : mem[rptr];
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     dout <= '0;
    else if (rd_ok) dout <= mem[rptr];
  end
`endif

endmodule
